// File: rtl/limb_wb_bridge.sv
// LIMB byte-bus to Wishbone classic master. LIMB signals are oversampled in the clk domain;
// assembled address/data words drive single-beat Wishbone cycles with burst autoincrement.
module limb_wb_bridge #(
   parameter  int ADDR_W      = 36,
   parameter  int DATA_BYTES  = 4,
   parameter  int SYNC_STAGES = 2,
   parameter  int TIMEOUT     = 255,
   localparam int ADDR_BYTES  = (ADDR_W + 7) / 8,
   localparam int DW          = 8 * DATA_BYTES
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            limb_d_in,
   output logic [7:0]            limb_d_out,
   output logic                  limb_d_oe,
   input  logic                  limb_clk,
   input  logic                  limb_nrd,
   input  logic                  limb_start,
   output logic                  limb_nwait,
   output logic                  limb_nerr,
   output logic [ADDR_W-1:0]     wb_adr_o,
   output logic [DW-1:0]         wb_dat_o,
   input  logic [DW-1:0]         wb_dat_i,
   output logic [DATA_BYTES-1:0] wb_sel_o,
   output logic                  wb_we_o,
   output logic                  wb_stb_o,
   output logic                  wb_cyc_o,
   input  logic                  wb_ack_i,
   input  logic                  wb_err_i
);

   localparam int MAXB = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
   localparam int IW   = $clog2(MAXB + 1);
   localparam int TW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   // Synchroniser word layout: {clk, start, nrd, data}; nrd resets high so the pad is not driven.
   localparam logic [10:0] SYNC_RST = 11'h100;

   typedef enum logic [1:0] {IDLE, ADDR, DATA, BUS} state_t;

   logic [SYNC_STAGES-1:0][10:0] sync_q, sync_d;
   logic                         lclk_dly_q, lclk_dly_d;
   logic                         s_clk, s_start, s_nrd, lclk_rise;
   logic [7:0]                   s_d;

   state_t                       state_q, state_d;
   logic [IW-1:0]                idx_q, idx_d;
   logic                         rd_valid_q, rd_valid_d;
   logic [ADDR_W-1:0]            adr_q, adr_d;
   logic [DW-1:0]                dat_q, dat_d;
   logic [DW-1:0]                rdata_q, rdata_d;
   logic                         we_q, we_d;
   logic                         nerr_q, nerr_d;
   logic                         oe_q, oe_d;
   logic [TW-1:0]                tmo_q, tmo_d, tmo_nxt;
   logic                         tmo_hit;
   logic [ADDR_BYTES*8-1:0]      adr_ext;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], {limb_clk, limb_start, limb_nrd, limb_d_in}};
   end

   assign s_clk      = sync_q[SYNC_STAGES-1][10];
   assign s_start    = sync_q[SYNC_STAGES-1][9];
   assign s_nrd      = sync_q[SYNC_STAGES-1][8];
   assign s_d        = sync_q[SYNC_STAGES-1][7:0];
   assign lclk_dly_d = s_clk;
   assign lclk_rise  = s_clk & ~lclk_dly_q;
   assign oe_d       = ~s_nrd;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q     <= {SYNC_STAGES{SYNC_RST}};
         lclk_dly_q <= 1'b0;
         state_q    <= IDLE;
         idx_q      <= '0;
         rd_valid_q <= 1'b0;
         adr_q      <= '0;
         dat_q      <= '0;
         rdata_q    <= '0;
         we_q       <= 1'b0;
         nerr_q     <= 1'b1;
         oe_q       <= 1'b0;
         tmo_q      <= '0;
      end else begin
         sync_q     <= sync_d;
         lclk_dly_q <= lclk_dly_d;
         state_q    <= state_d;
         idx_q      <= idx_d;
         rd_valid_q <= rd_valid_d;
         adr_q      <= adr_d;
         dat_q      <= dat_d;
         rdata_q    <= rdata_d;
         we_q       <= we_d;
         nerr_q     <= nerr_d;
         oe_q       <= oe_d;
         tmo_q      <= tmo_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      rd_valid_d = rd_valid_q;
      adr_d      = adr_q;
      dat_d      = dat_q;
      rdata_d    = rdata_q;
      we_d       = we_q;
      nerr_d     = nerr_q;
      tmo_d      = tmo_q;
      tmo_nxt    = tmo_q + TW'(1);
      tmo_hit    = (TIMEOUT != 0) && (tmo_nxt == TW'(TIMEOUT));
      adr_ext    = '0;
      adr_ext[ADDR_W-1:0] = adr_q;

      if (state_q == BUS) begin
         tmo_d = tmo_nxt;
         // A same-cycle ack+err is an error; a late ack still beats the timeout.
         if (wb_err_i || (!wb_ack_i && tmo_hit)) begin
            state_d = DATA;
            nerr_d  = 1'b0;
            rdata_d = '1;
            if (!we_q) begin
               rd_valid_d = 1'b1;
               idx_d      = '0;
            end
         end else if (wb_ack_i) begin
            state_d = DATA;
            if (we_q) begin
               adr_d = adr_q + ADDR_W'(1);
            end else begin
               rdata_d    = wb_dat_i;
               rd_valid_d = 1'b1;
               idx_d      = '0;
            end
         end
      end else if (lclk_rise) begin
         if (s_start) begin
            adr_ext[7:0] = s_d;
            adr_d        = adr_ext[ADDR_W-1:0];
            rd_valid_d   = 1'b0;
            nerr_d       = 1'b1;
            if (ADDR_BYTES == 1) begin
               state_d = DATA;
               idx_d   = '0;
            end else begin
               state_d = ADDR;
               idx_d   = IW'(1);
            end
         end else if (state_q == ADDR) begin
            for (int b = 0; b < ADDR_BYTES; b++)
               if (idx_q == IW'(b)) adr_ext[b*8 +: 8] = s_d;
            adr_d = adr_ext[ADDR_W-1:0];
            if (idx_q == IW'(ADDR_BYTES - 1)) begin
               idx_d   = '0;
               state_d = DATA;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end else if (state_q == DATA) begin
            if (s_nrd) begin
               for (int b = 0; b < DATA_BYTES; b++)
                  if (idx_q == IW'(b)) dat_d[b*8 +: 8] = s_d;
               if (idx_q == IW'(DATA_BYTES - 1)) begin
                  idx_d   = '0;
                  state_d = BUS;
                  we_d    = 1'b1;
                  tmo_d   = '0;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end else if (!rd_valid_q) begin
               state_d = BUS;
               we_d    = 1'b0;
               tmo_d   = '0;
            end else if (idx_q == IW'(DATA_BYTES - 1)) begin
               // Last byte of the word consumed: prefetch the next word.
               idx_d      = '0;
               rd_valid_d = 1'b0;
               adr_d      = adr_q + ADDR_W'(1);
               state_d    = BUS;
               we_d       = 1'b0;
               tmo_d      = '0;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
      end
   end

   always_comb begin
      limb_d_out = '0;
      for (int b = 0; b < DATA_BYTES; b++)
         if (idx_q == IW'(b)) limb_d_out = rdata_q[b*8 +: 8];
   end

   assign limb_d_oe  = oe_q;
   assign limb_nwait = (state_q != BUS);
   assign limb_nerr  = nerr_q;
   assign wb_adr_o   = adr_q;
   assign wb_dat_o   = dat_q;
   assign wb_sel_o   = '1;
   assign wb_we_o    = we_q;
   assign wb_cyc_o   = (state_q == BUS);
   assign wb_stb_o   = (state_q == BUS);

endmodule

// File: tb/tb_limb_wb_bridge.sv
// Directed bench for limb_wb_bridge: writes, read bursts, wrap, bus error, timeout, reset mid-cycle.
module tb_limb_wb_bridge;
   localparam int ADDR_W = 36;
   localparam int DB     = 4;
   localparam int SYNC   = 2;
   localparam int TMO    = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [7:0]        limb_d_in = '0;
   logic [7:0]        limb_d_out;
   logic              limb_d_oe;
   logic              limb_clk = 1'b0;
   logic              limb_nrd = 1'b1;
   logic              limb_start = 1'b0;
   logic              limb_nwait, limb_nerr;
   logic [ADDR_W-1:0] wb_adr_o;
   logic [31:0]       wb_dat_o;
   logic [31:0]       wb_dat_i = '0;
   logic [DB-1:0]     wb_sel_o;
   logic              wb_we_o, wb_stb_o, wb_cyc_o;
   logic              wb_ack_i = 1'b0, wb_err_i = 1'b0;

   int checks = 0;
   int errors = 0;

   // Slave model: 0 = ack, 1 = err, 2 = never respond; responds after slv_lat waiting cycles.
   int                slv_mode = 0;
   int                slv_lat  = 2;
   int                wait_cnt = 0;
   int                n_log    = 0;
   int                cur_len  = 0;
   int                last_len = 0;
   logic [ADDR_W-1:0] log_adr [0:63];
   logic              log_we  [0:63];
   logic [31:0]       log_dat [0:63];
   logic [31:0]       rd_data [0:63];

   always #5 clk = ~clk;

   limb_wb_bridge #(.ADDR_W(ADDR_W), .DATA_BYTES(DB), .SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .limb_d_in(limb_d_in), .limb_d_out(limb_d_out), .limb_d_oe(limb_d_oe),
      .limb_clk(limb_clk), .limb_nrd(limb_nrd), .limb_start(limb_start), .limb_nwait(limb_nwait),
      .limb_nerr(limb_nerr), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
      .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
      .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i));

   always @(posedge clk) begin
      wb_ack_i <= 1'b0;
      wb_err_i <= 1'b0;
      if (wb_cyc_o) cur_len <= cur_len + 1;
      else if (cur_len != 0) begin
         last_len <= cur_len;
         cur_len  <= 0;
      end
      if (wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i) begin
         if (wait_cnt == slv_lat && slv_mode != 2) begin
            wait_cnt <= 0;
            if (slv_mode == 1) wb_err_i <= 1'b1;
            else begin
               wb_ack_i       <= 1'b1;
               wb_dat_i       <= rd_data[n_log];
               log_adr[n_log] <= wb_adr_o;
               log_we[n_log]  <= wb_we_o;
               log_dat[n_log] <= wb_dat_o;
               n_log          <= n_log + 1;
            end
         end else wait_cnt <= wait_cnt + 1;
      end else if (!wb_cyc_o) wait_cnt <= 0;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One LIMB byte strobe; waits (bounded) for the bridge to release nwait.
   task automatic strobe(input logic [7:0] d, input logic st, input logic nrd);
      int n;
      @(negedge clk);
      limb_d_in = d; limb_start = st; limb_nrd = nrd; limb_clk = 1'b1;
      repeat (SYNC + 3) @(negedge clk);
      n = 0;
      while (!limb_nwait && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!limb_nwait) chk("nwait_release", {63'd0, limb_nwait}, 64'd1);
      limb_clk = 1'b0; limb_start = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic header(input logic [39:0] a, input logic nrd);
      strobe(a[7:0], 1'b1, nrd);
      for (int i = 1; i < 5; i++) strobe(a[i*8 +: 8], 1'b0, nrd);
   endtask

   task automatic wr_word(input logic [31:0] w);
      for (int i = 0; i < DB; i++) strobe(w[i*8 +: 8], 1'b0, 1'b1);
   endtask

   initial begin
      int base, n;
      logic [63:0] exp_bytes;
      for (int i = 0; i < 64; i++) rd_data[i] = 32'h0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_cyc", {63'd0, wb_cyc_o}, 64'd0);
      chk("rst_stb", {63'd0, wb_stb_o}, 64'd0);
      chk("rst_we", {63'd0, wb_we_o}, 64'd0);
      chk("rst_nwait", {63'd0, limb_nwait}, 64'd1);
      chk("rst_nerr", {63'd0, limb_nerr}, 64'd1);
      chk("rst_oe", {63'd0, limb_d_oe}, 64'd0);
      chk("rst_adr", {28'd0, wb_adr_o}, 64'd0);
      chk("rst_dat", {32'd0, wb_dat_o}, 64'd0);
      chk("rst_sel", {60'd0, wb_sel_o}, 64'hF);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("idle_oe_write_dir", {63'd0, limb_d_oe}, 64'd0);

      // Single write
      base = n_log;
      header(40'h0876543210, 1'b1);
      wr_word(32'hDEADBEEF);
      chk("wr_count", n_log - base, 64'd1);
      chk("wr_adr", {28'd0, log_adr[base]}, 64'h876543210);
      chk("wr_we", {63'd0, log_we[base]}, 64'd1);
      chk("wr_dat", {32'd0, log_dat[base]}, 64'hDEADBEEF);
      chk("wr_busy_len", last_len, 64'd4);
      chk("wr_adr_inc", {28'd0, wb_adr_o}, 64'h876543211);

      // Read burst of two words
      base = n_log;
      rd_data[base] = 32'h11223344;
      rd_data[base + 1] = 32'h55667788;
      header(40'h000000000F, 1'b0);
      chk("rd_oe", {63'd0, limb_d_oe}, 64'd1);
      exp_bytes = 64'h5566778811223344;
      for (int i = 0; i < 8; i++) begin
         strobe(8'h00, 1'b0, 1'b0);
         chk($sformatf("rd_byte%0d", i), {56'd0, limb_d_out}, {56'd0, exp_bytes[i*8 +: 8]});
      end
      chk("rd_count", n_log - base, 64'd2);
      chk("rd_adr0", {28'd0, log_adr[base]}, 64'h00000000F);
      chk("rd_we0", {63'd0, log_we[base]}, 64'd0);
      chk("rd_adr1", {28'd0, log_adr[base + 1]}, 64'h000000010);
      chk("rd_nerr", {63'd0, limb_nerr}, 64'd1);

      // Write burst across the address wrap
      base = n_log;
      header(40'h0FFFFFFFFF, 1'b1);
      wr_word(32'hA0A0A0A0);
      wr_word(32'hB1B1B1B1);
      wr_word(32'hC2C2C2C2);
      chk("wrap_count", n_log - base, 64'd3);
      chk("wrap_adr0", {28'd0, log_adr[base]}, 64'hFFFFFFFFF);
      chk("wrap_adr1", {28'd0, log_adr[base + 1]}, 64'h000000000);
      chk("wrap_adr2", {28'd0, log_adr[base + 2]}, 64'h000000001);
      chk("wrap_dat2", {32'd0, log_dat[base + 2]}, 64'hC2C2C2C2);
      chk("wrap_adr_final", {28'd0, wb_adr_o}, 64'h000000002);

      // Bus error on a read
      slv_mode = 1;
      header(40'h0000000123, 1'b0);
      strobe(8'h00, 1'b0, 1'b0);
      chk("err_nerr", {63'd0, limb_nerr}, 64'd0);
      chk("err_byte0", {56'd0, limb_d_out}, 64'hFF);
      chk("err_adr", {28'd0, wb_adr_o}, 64'h000000123);
      strobe(8'h00, 1'b0, 1'b0);
      chk("err_byte1", {56'd0, limb_d_out}, 64'hFF);
      chk("err_nerr_sticky", {63'd0, limb_nerr}, 64'd0);
      slv_mode = 0;
      strobe(8'h00, 1'b1, 1'b1);
      chk("err_cleared_by_start", {63'd0, limb_nerr}, 64'd1);

      // Timeout with a silent slave
      slv_mode = 2;
      header(40'h0000000040, 1'b1);
      wr_word(32'h12345678);
      chk("tmo_len", last_len, 64'd16);
      chk("tmo_nerr", {63'd0, limb_nerr}, 64'd0);
      chk("tmo_nwait", {63'd0, limb_nwait}, 64'd1);
      chk("tmo_cyc", {63'd0, wb_cyc_o}, 64'd0);
      chk("tmo_adr", {28'd0, wb_adr_o}, 64'h000000040);

      // Reset two clocks into a bus cycle
      header(40'h0000000055, 1'b1);
      for (int i = 0; i < 3; i++) strobe(8'h11, 1'b0, 1'b1);
      @(negedge clk);
      limb_d_in = 8'h22; limb_clk = 1'b1;
      n = 0;
      while (!wb_cyc_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("rstbus_entered", {63'd0, wb_cyc_o}, 64'd1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("rstbus_cyc", {63'd0, wb_cyc_o}, 64'd0);
      chk("rstbus_stb", {63'd0, wb_stb_o}, 64'd0);
      chk("rstbus_nwait", {63'd0, limb_nwait}, 64'd1);
      chk("rstbus_nerr", {63'd0, limb_nerr}, 64'd1);
      chk("rstbus_adr", {28'd0, wb_adr_o}, 64'd0);
      chk("rstbus_dat", {32'd0, wb_dat_o}, 64'd0);
      chk("rstbus_oe", {63'd0, limb_d_oe}, 64'd0);
      limb_clk = 1'b0;
      slv_mode = 0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      base = n_log;
      header(40'h00000000AB, 1'b1);
      wr_word(32'h04030201);
      chk("post_rst_count", n_log - base, 64'd1);
      chk("post_rst_adr", {28'd0, log_adr[base]}, 64'h0000000AB);
      chk("post_rst_dat", {32'd0, log_dat[base]}, 64'h04030201);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: observed hang expected completion");
      $fatal(1, "bench timed out");
   end
endmodule
